// File: rtl/hwag_pkg.sv
// Shared definitions for the hardware angle generator sync controller and its register decode.
package hwag_pkg;

  localparam int ERR_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_SEARCH = 3'd2,
    ST_RUN    = 3'd3
  } hwag_state_e;

endpackage

// File: rtl/hwag_sync_ctrl_if.sv
// Sensor/control bundle for hwag_sync_ctrl: master drives the qualified sensor inputs, slave is the controller.
interface hwag_sync_ctrl_if
  import hwag_pkg::*;
#(
  parameter int ERR_W = ERR_W_DEF
);
  logic             cape;
  logic             tooth_edge;
  logic             pcnt_ovf;
  logic             period_ok;
  logic             gap_found;
  logic             gap_run;
  logic             tooth_top;
  logic [ERR_W-1:0] err_max;
  logic             pcap_ena;
  logic             tcnt_ena;
  logic             tcnt_srst;
  logic             sync;
  logic [2:0]       state;
  logic [ERR_W-1:0] err_cnt;
  logic             irq_acq;
  logic             irq_lost;
  logic             irq_gerr;

  modport master (
    output cape, tooth_edge, pcnt_ovf, period_ok, gap_found, gap_run, tooth_top, err_max,
    input  pcap_ena, tcnt_ena, tcnt_srst, sync, state, err_cnt, irq_acq, irq_lost, irq_gerr
  );

  modport slave (
    input  cape, tooth_edge, pcnt_ovf, period_ok, gap_found, gap_run, tooth_top, err_max,
    output pcap_ena, tcnt_ena, tcnt_srst, sync, state, err_cnt, irq_acq, irq_lost, irq_gerr
  );
endinterface

// File: rtl/hwag_sync_ctrl.sv
// Crank-wheel synchronisation FSM: fills the period history, searches for the gap tooth,
// then tracks the wheel in RUN, counting gap errors until sync is declared lost.
module hwag_sync_ctrl
  import hwag_pkg::*;
#(
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cape,
  input  logic             tooth_edge,
  input  logic             pcnt_ovf,
  input  logic             period_ok,
  input  logic             gap_found,
  input  logic             gap_run,
  input  logic             tooth_top,
  input  logic [ERR_W-1:0] err_max,
  output logic             pcap_ena,
  output logic             tcnt_ena,
  output logic             tcnt_srst,
  output logic             sync,
  output logic [2:0]       state,
  output logic [ERR_W-1:0] err_cnt,
  output logic             irq_acq,
  output logic             irq_lost,
  output logic             irq_gerr
);

  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [1:0]       fill_q, fill_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             sync_q, sync_d;

  logic [ERR_W-1:0] err_thr;
  logic [ERR_W-1:0] err_inc;
  logic             bad_edge;

  assign err_thr  = (err_max == '0) ? ERR_ONE : err_max;
  assign err_inc  = (&err_q) ? err_q : err_q + ERR_ONE;
  assign bad_edge = (tooth_top ^ gap_run) | ~period_ok;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    err_d     = err_q;
    pcap_ena  = 1'b0;
    tcnt_ena  = 1'b0;
    tcnt_srst = 1'b0;
    irq_acq   = 1'b0;
    irq_lost  = 1'b0;
    irq_gerr  = 1'b0;

    if (!cape) begin
      state_d = ST_IDLE;
      fill_d  = '0;
      err_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FILL;
          fill_d  = '0;
        end

        ST_FILL: begin
          pcap_ena = tooth_edge;
          if (pcnt_ovf) begin
            fill_d = '0;
          end else if (tooth_edge) begin
            if (fill_q == 2'd2) begin
              state_d = ST_SEARCH;
              fill_d  = '0;
            end else begin
              fill_d = fill_q + 2'd1;
            end
          end
        end

        ST_SEARCH: begin
          pcap_ena = tooth_edge;
          if (pcnt_ovf) begin
            state_d = ST_FILL;
            fill_d  = '0;
          end else if (tooth_edge && period_ok && gap_found) begin
            state_d   = ST_RUN;
            irq_acq   = 1'b1;
            tcnt_srst = 1'b1;
          end
        end

        ST_RUN: begin
          // Enables still follow the edge under a stall; only the state decision is overridden.
          tcnt_ena = tooth_edge;
          pcap_ena = tooth_edge & ~tooth_top;
          if (pcnt_ovf) begin
            state_d  = ST_FILL;
            fill_d   = '0;
            err_d    = '0;
            irq_lost = 1'b1;
          end else if (tooth_edge) begin
            // The tooth counter is realigned at the gap even when the period check fails,
            // but a failed check still counts as an error rather than a good gap.
            tcnt_srst = tooth_top & gap_run;
            if (bad_edge) begin
              irq_gerr = 1'b1;
              if (err_inc >= err_thr) begin
                state_d  = ST_FILL;
                fill_d   = '0;
                err_d    = '0;
                irq_lost = 1'b1;
              end else begin
                err_d = err_inc;
              end
            end else if (tooth_top) begin
              err_d = '0;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          fill_d  = '0;
          err_d   = '0;
        end
      endcase
    end

    sync_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      err_q   <= '0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      sync_q  <= sync_d;
    end
  end

  assign state   = state_q;
  assign sync    = sync_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_hwag_sync_ctrl.sv
// Directed scenarios plus randomized traffic for hwag_sync_ctrl, checked against a behavioural model.
module tb_hwag_sync_ctrl;
  import hwag_pkg::*;

  localparam int ERR_W = 4;
  localparam int ERR_SAT = (1 << ERR_W) - 1;

  typedef struct packed {
    logic             pcap;
    logic             tcnt;
    logic             srst;
    logic             sync;
    logic [2:0]       state;
    logic [ERR_W-1:0] err;
    logic             acq;
    logic             lost;
    logic             gerr;
  } outs_t;

  logic clk;
  logic rst;
  hwag_sync_ctrl_if #(.ERR_W(ERR_W)) bus ();

  hwag_sync_ctrl #(.ERR_W(ERR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cape       (bus.cape),
    .tooth_edge (bus.tooth_edge),
    .pcnt_ovf   (bus.pcnt_ovf),
    .period_ok  (bus.period_ok),
    .gap_found  (bus.gap_found),
    .gap_run    (bus.gap_run),
    .tooth_top  (bus.tooth_top),
    .err_max    (bus.err_max),
    .pcap_ena   (bus.pcap_ena),
    .tcnt_ena   (bus.tcnt_ena),
    .tcnt_srst  (bus.tcnt_srst),
    .sync       (bus.sync),
    .state      (bus.state),
    .err_cnt    (bus.err_cnt),
    .irq_acq    (bus.irq_acq),
    .irq_lost   (bus.irq_lost),
    .irq_gerr   (bus.irq_gerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: phase (0 idle,1 fill,2 search,3 run), edges seen while filling, error count
  int m_st = 0, m_fill = 0, m_err = 0;
  int emax = 3;
  outs_t last;
  int gerr_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t s;
    s.pcap  = bus.pcap_ena;
    s.tcnt  = bus.tcnt_ena;
    s.srst  = bus.tcnt_srst;
    s.sync  = bus.sync;
    s.state = bus.state;
    s.err   = bus.err_cnt;
    s.acq   = bus.irq_acq;
    s.lost  = bus.irq_lost;
    s.gerr  = bus.irq_gerr;
    return s;
  endfunction

  // One clock: drive inputs, predict and compare at the falling edge, advance the model.
  task automatic step(input bit c, input bit e, input bit ov, input bit pk,
                      input bit gf, input bit gr, input bit tt);
    outs_t x;
    int n_st, n_fill, n_err, thr, cnt;
    bus.cape = c; bus.tooth_edge = e; bus.pcnt_ovf = ov; bus.period_ok = pk;
    bus.gap_found = gf; bus.gap_run = gr; bus.tooth_top = tt;
    bus.err_max = emax[ERR_W-1:0];

    x = '0;
    x.state = m_st[2:0];
    x.sync  = (m_st == 3);
    x.err   = m_err[ERR_W-1:0];
    n_st = m_st; n_fill = m_fill; n_err = m_err;
    thr = (emax == 0) ? 1 : emax;
    if (!c) begin
      n_st = 0; n_fill = 0; n_err = 0;
    end else if (m_st == 0) begin
      n_st = 1; n_fill = 0;
    end else if (m_st == 1) begin
      x.pcap = e;
      if (ov) n_fill = 0;
      else if (e) begin
        n_fill = m_fill + 1;
        if (n_fill == 3) begin n_st = 2; n_fill = 0; end
      end
    end else if (m_st == 2) begin
      x.pcap = e;
      if (ov) begin n_st = 1; n_fill = 0; end
      else if (e && pk && gf) begin n_st = 3; x.acq = 1; x.srst = 1; end
    end else begin
      x.tcnt = e;
      x.pcap = e && !tt;
      if (ov) begin
        n_st = 1; n_fill = 0; n_err = 0; x.lost = 1;
      end else if (e) begin
        x.srst = tt && gr;
        if ((tt != gr) || !pk) begin
          x.gerr = 1;
          cnt = (m_err + 1 > ERR_SAT) ? ERR_SAT : m_err + 1;
          if (cnt >= thr) begin
            x.lost = 1; n_err = 0; n_st = 1; n_fill = 0;
          end else n_err = cnt;
        end else if (tt) n_err = 0;
      end
    end

    @(negedge clk);
    last = sample();
    chk("outs", last, x);
    if (last.gerr) gerr_seen++;
    @(posedge clk);
    #1;
    m_st = n_st; m_fill = n_fill; m_err = n_err;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    m_st = 0; m_fill = 0; m_err = 0;
    chk("rst_outs", sample(), '0);
    rst = 1'b1;
    #1;
  endtask

  task automatic acquire();
    step(1, 0, 0, 1, 0, 0, 0);
    if (m_st == 0) step(1, 0, 0, 1, 0, 0, 0);
    repeat (3) step(1, 1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 1, 1, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    bus.cape = 0; bus.tooth_edge = 0; bus.pcnt_ovf = 0; bus.period_ok = 0;
    bus.gap_found = 0; bus.gap_run = 0; bus.tooth_top = 0; bus.err_max = '0;
    #12;
    chk("reset_state", sample(), '0);
    @(posedge clk); #1;
    rst = 1'b1;

    // acquire
    emax = 3;
    step(1, 0, 0, 1, 0, 0, 0);
    chk("acq_fill", bus.state, 1);
    repeat (3) step(1, 1, 0, 1, 0, 0, 0);
    chk("acq_search", bus.state, 2);
    step(1, 1, 0, 1, 1, 0, 0);
    chk("acq_irq", {last.acq, last.srst}, 2'b11);
    chk("acq_sync", {bus.sync, bus.state}, 4'b1011);

    // good gap clears accumulated errors
    repeat (2) step(1, 1, 0, 1, 0, 1, 0);
    chk("gap_err2", bus.err_cnt, 2);
    step(1, 1, 0, 1, 0, 1, 1);
    chk("gap_srst_pcap", {last.srst, last.pcap}, 2'b10);
    chk("gap_err0", bus.err_cnt, 0);

    // loss after err_max consecutive unexpected gaps
    gerr_seen = 0;
    repeat (3) step(1, 1, 0, 1, 0, 1, 0);
    chk("loss_gerr", gerr_seen, 3);
    chk("loss_lost", last.lost, 1);
    chk("loss_state", {bus.state, bus.err_cnt}, {3'd1, 4'd0});

    // stall overrides coincident edge
    acquire();
    step(1, 1, 1, 1, 0, 1, 0);
    chk("stall_pulses", {last.lost, last.tcnt, last.gerr}, 3'b110);
    chk("stall_state", bus.state, 1);

    // disable while running
    acquire();
    step(1, 1, 0, 1, 0, 1, 0);
    chk("dis_err1", bus.err_cnt, 1);
    step(0, 1, 0, 1, 0, 1, 0);
    chk("dis_pulses", {last.pcap, last.tcnt, last.srst, last.acq, last.lost, last.gerr}, 0);
    chk("dis_state", {bus.state, bus.err_cnt}, 0);

    // reset mid-FILL restarts the fill count
    step(1, 0, 0, 1, 0, 0, 0);
    repeat (2) step(1, 1, 0, 1, 0, 0, 0);
    bus.tooth_edge = 1; bus.gap_found = 1;
    do_reset();
    step(1, 0, 0, 1, 0, 0, 0);
    chk("rst_fill", bus.state, 1);
    repeat (2) step(1, 1, 0, 1, 0, 0, 0);
    chk("rst_still_fill", bus.state, 1);
    step(1, 1, 0, 1, 0, 0, 0);
    chk("rst_search", bus.state, 2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 99) == 0) emax = $urandom_range(0, 5);
      step($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hwag_sync_ctrl.md
HWAG_SYNC_CTRL -- requirements
Module: hwag_sync_ctrl

Interface
REQ-001 SHALL have parameter ERR_W, default 4, meaning width of the error counter and the threshold.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- cape  in  1  capture enable; low forces IDLE.
- tooth_edge  in  1  one-cycle qualified sensor edge pulse.
- pcnt_ovf  in  1  one-cycle period counter overflow pulse (stall).
- period_ok  in  1  last three periods are within the min/max window.
- gap_found  in  1  gap-search comparator result.
- gap_run  in  1  running-gap check result.
- tooth_top  in  1  tooth counter is at its programmed top (gap tooth).
- err_max  in  ERR_W  consecutive-error threshold; 0 is treated as 1.
- pcap_ena  out  1  period capture shift enable.
- tcnt_ena  out  1  tooth counter increment enable.
- tcnt_srst  out  1  tooth counter synchronous clear.
- sync  out  1  synchronised (RUN state) flag.
- state  out  3  current state code.
- err_cnt  out  ERR_W  consecutive error count.
- irq_acq, irq_lost, irq_gerr  out  1  one-cycle event pulses.

Function
REQ-003 SHALL implement the states IDLE=0, FILL=1, SEARCH=2, RUN=3; codes 4-7 SHALL recover to IDLE on the next cycle.
REQ-004 SHALL treat cape=0 as top priority: next state IDLE, err_cnt cleared, all pulses 0, regardless of other inputs.
REQ-005 IDLE: with cape=1, SHALL go to FILL on the next cycle.
REQ-006 FILL: SHALL count tooth_edge with a 2-bit fill counter and assert pcap_ena=tooth_edge combinationally.
REQ-007 FILL: on the 3rd edge, SHALL enter SEARCH and clear the fill counter.
REQ-008 SEARCH: an edge with period_ok & gap_found SHALL enter RUN and pulse irq_acq and tcnt_srst in the same cycle as the edge.
REQ-009 SEARCH: an edge without period_ok & gap_found SHALL stay in SEARCH; pcap_ena SHALL follow tooth_edge.
REQ-010 RUN: tcnt_ena SHALL follow tooth_edge; pcap_ena SHALL equal tooth_edge & ~tooth_top, so the gap period is not shifted in.
REQ-011 RUN: an edge with tooth_top & gap_run SHALL be a good gap: assert tcnt_srst and clear err_cnt.
REQ-012 RUN: any of the following on an edge SHALL be an error, counted at most once per edge:
- tooth_top & ~gap_run (missing gap);
- ~tooth_top & gap_run (unexpected gap);
- ~period_ok.
REQ-013 On an error, SHALL pulse irq_gerr and increment err_cnt, saturating at all-ones.
REQ-014 When the incremented err_cnt reaches max(err_max,1), SHALL pulse irq_lost, clear err_cnt, clear the fill counter and enter FILL.
REQ-015 pcnt_ovf in SEARCH or RUN SHALL enter FILL; from RUN it SHALL also pulse irq_lost.
REQ-016 pcnt_ovf SHALL override a coincident tooth_edge; pcnt_ovf in FILL SHALL restart the fill count.
REQ-017 A good edge in RUN without tooth_top SHALL leave err_cnt unchanged; errors are cleared only at a good gap.
REQ-018 sync SHALL be 1 exactly when state=RUN; state, sync and err_cnt SHALL be registered.
REQ-019 pcap_ena, tcnt_ena, tcnt_srst and the irq_* outputs SHALL be combinational from registered state and the current-cycle inputs (zero latency), active only while cape=1.
REQ-020 Latency: the state change SHALL be visible on the cycle after the qualifying edge.

Reset
REQ-021 While rst=0, SHALL hold state=IDLE, fill counter=0, err_cnt=0 and sync=0; all outputs SHALL be 0.
REQ-022 Reset assertion mid-operation SHALL abort immediately, with no pulse emitted.
REQ-023 After rst deasserts with cape=1, SHALL reach FILL on the first clock.

Structure
REQ-024 State encoding and the ERR_W default SHALL live in the shared package hwag_pkg; the same package SHALL be used by the register decode.
REQ-025 SHALL be one module with no sub-modules, optionally containing a separate next-state function.

Verification
REQ-026 The bench SHALL cover the directed scenarios below:
- Acquire: cape=1, then 3 edges, then an edge with period_ok=gap_found=1 -> states 1,2,3; irq_acq and tcnt_srst asserted on that edge; sync=1 the next cycle.
- Good gap: in RUN, err_cnt=2, edge with tooth_top=gap_run=1 -> tcnt_srst=1, pcap_ena=0, err_cnt=0.
- Loss: err_max=3, three consecutive edges with tooth_top=0 and gap_run=1 -> irq_gerr pulsed 3 times; irq_lost on the 3rd; state=FILL; err_cnt=0.
- Stall: in RUN, pcnt_ovf and tooth_edge in the same cycle -> irq_lost=1, tcnt_ena still asserted for that edge, state=FILL, no irq_gerr.
- Disable: cape dropped in RUN with err_cnt=1 -> IDLE next cycle, err_cnt=0, no pulses.
- Reset: rst low mid-FILL after 2 edges -> all outputs 0; after release, 3 further edges are required to reach SEARCH.
